imem_loader: RTL and testbench

- Program loader that fills the 16-word instruction memory from a byte stream before the VLIW core runs.
- Accepts bytes over a valid/ready handshake and packs every four bytes into one 32-bit word.
- Issues single-cycle memWrite strobes with address and data to the instruction memory write port.
- Holds the core (cpu_hold) for the whole load sequence.

---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_loader_if;
    logic        start;
    logic        abort;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        memWrite;
    logic [31:0] pc;
    logic [31:0] dataIn;
    logic        cpu_hold;
    logic        done;
    logic [4:0]  word_count;

    modport master (
        input  start, abort, byte_valid, byte_data,
        output byte_ready, memWrite, pc, dataIn, cpu_hold, done, word_count
    );

    modport slave (
        output start, abort, byte_valid, byte_data,
        input  byte_ready, memWrite, pc, dataIn, cpu_hold, done, word_count
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: packs a byte stream little-endian into 32-bit words and writes
// them to instruction memory while holding the core.
module imem_loader #(
    parameter int unsigned NUM_WORDS = 16,
    parameter int unsigned ADDR_STEP = 2
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.master bus
);
    typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} stateT;

    localparam logic [3:0] LastIdx = 4'(NUM_WORDS - 1);

    stateT       stateQ, stateD;
    logic [1:0]  byteCntQ;
    logic [3:0]  wordIdxQ;
    logic [4:0]  wordCountQ;
    logic [31:0] pcQ, dataInQ;
    logic        byteReadyQ, memWriteQ, doneQ, cpuHoldQ;
    logic        byteFire;

    // A byte offered alongside abort is left unconsumed.
    assign byteFire = (stateQ == StCollect) && byteReadyQ && bus.byte_valid && !bus.abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (bus.start) stateD = StCollect;
            end
            StCollect: begin
                if (bus.abort) begin
                    stateD = StIdle;
                end else if (byteFire && (byteCntQ == 2'd3)) begin
                    stateD = StWrite;
                end
            end
            StWrite: begin
                if (bus.abort) begin
                    stateD = StIdle;
                end else if (wordIdxQ == LastIdx) begin
                    stateD = StDone;
                end else begin
                    stateD = StCollect;
                end
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // Handshake and strobe outputs are registered from the next state so they
    // are glitch-free and line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byteReadyQ <= 1'b0;
            memWriteQ  <= 1'b0;
            doneQ      <= 1'b0;
            cpuHoldQ   <= 1'b0;
        end else begin
            byteReadyQ <= (stateD == StCollect);
            memWriteQ  <= (stateD == StWrite);
            doneQ      <= (stateD == StDone);
            cpuHoldQ   <= (stateD != StIdle);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byteCntQ   <= 2'd0;
            wordIdxQ   <= 4'd0;
            wordCountQ <= 5'd0;
            pcQ        <= 32'd0;
            dataInQ    <= 32'd0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (bus.start) begin
                        byteCntQ   <= 2'd0;
                        wordIdxQ   <= 4'd0;
                        wordCountQ <= 5'd0;
                        pcQ        <= 32'd0;
                    end
                end
                StCollect: begin
                    if (bus.abort) begin
                        byteCntQ <= 2'd0;
                    end else if (byteFire) begin
                        dataInQ[{byteCntQ, 3'b000} +: 8] <= bus.byte_data;
                        byteCntQ <= byteCntQ + 2'd1;
                    end
                end
                StWrite: begin
                    wordCountQ <= wordCountQ + 5'd1;
                    if (!bus.abort && (wordIdxQ != LastIdx)) begin
                        wordIdxQ <= wordIdxQ + 4'd1;
                        pcQ      <= pcQ + ADDR_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = byteReadyQ;
    assign bus.memWrite   = memWriteQ;
    assign bus.done       = doneQ;
    assign bus.cpu_hold   = cpuHoldQ;
    assign bus.pc         = pcQ;
    assign bus.dataIn     = dataInQ;
    assign bus.word_count = wordCountQ;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 1-word and a 16-word instance share clock and reset.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if b1 ();
    imem_loader_if b16 ();

    imem_loader #(.NUM_WORDS(1), .ADDR_STEP(2)) u1 (.clk(clk), .reset(reset), .bus(b1));
    imem_loader #(.NUM_WORDS(16), .ADDR_STEP(2)) u16 (.clk(clk), .reset(reset), .bus(b16));

    int nCmp = 0;
    int nErr = 0;
    int byteIdx = 0;
    int wr16 = 0;
    int wr1 = 0;
    int done16 = 0;
    int cyc = 0;
    int doneBefore = 0;
    logic hs;
    logic [31:0] wrPc [64];
    logic [31:0] wrData [64];
    logic [7:0] bytes [4];

    always @(negedge clk) begin
        if (b16.memWrite && wr16 < 64) begin
            wrPc[wr16]   = b16.pc;
            wrData[wr16] = b16.dataIn;
            wr16++;
        end
        if (b1.memWrite) wr1++;
        if (b16.done) done16++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start16();
        wr16 = 0;
        b16.start = 1'b1;
        tick();
        b16.start = 1'b0;
        byteIdx = 0;
    endtask

    // Offer bytes 0,1,2,... until 'target' have been accepted.
    task automatic feed(input int target);
        int guard = 0;
        while (byteIdx < target && guard < 400) begin
            b16.byte_valid = 1'b1;
            b16.byte_data  = 8'(byteIdx);
            hs = b16.byte_ready;
            tick();
            if (hs) byteIdx++;
            guard++;
        end
        b16.byte_valid = 1'b0;
        check("feed_count", 32'(byteIdx), 32'(target));
    endtask

    initial begin
        bytes = '{8'h9C, 8'h5E, 8'hAB, 8'h12};
        {b1.start, b1.abort, b1.byte_valid, b1.byte_data} = '0;
        {b16.start, b16.abort, b16.byte_valid, b16.byte_data} = '0;

        // Reset values
        #12;
        check("rst_ready", 32'(b16.byte_ready), 0);
        check("rst_memwrite", 32'(b16.memWrite), 0);
        check("rst_hold", 32'(b16.cpu_hold), 0);
        check("rst_done", 32'(b16.done), 0);
        check("rst_pc", b16.pc, 0);
        check("rst_datain", b16.dataIn, 0);
        check("rst_wcount", 32'(b16.word_count), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ready", 32'(b16.byte_ready), 0);
        end
        check("idle_writes16", 32'(wr16), 0);
        check("idle_writes1", 32'(wr1), 0);

        // Single word on the 1-word instance
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        check("sw_ready", 32'(b1.byte_ready), 1);
        check("sw_hold", 32'(b1.cpu_hold), 1);
        for (int i = 0; i < 4; i++) begin
            b1.byte_valid = 1'b1;
            b1.byte_data  = bytes[i];
            tick();
        end
        b1.byte_valid = 1'b0;
        check("sw_memwrite", 32'(b1.memWrite), 1);
        check("sw_ready_wr", 32'(b1.byte_ready), 0);
        check("sw_pc", b1.pc, 32'h0);
        check("sw_data", b1.dataIn, 32'h12AB5E9C);
        tick();
        check("sw_done", 32'(b1.done), 1);
        check("sw_memwrite_off", 32'(b1.memWrite), 0);
        check("sw_wcount", 32'(b1.word_count), 1);
        check("sw_hold_done", 32'(b1.cpu_hold), 1);
        tick();
        check("sw_done_off", 32'(b1.done), 0);
        check("sw_hold_off", 32'(b1.cpu_hold), 0);
        check("sw_writes", 32'(wr1), 1);

        // Backpressure: valid on even cycles only, junk data on the others
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        for (int t = 0; t < 7; t++) begin
            b1.byte_valid = (t % 2 == 0);
            b1.byte_data  = (t % 2 == 0) ? bytes[t / 2] : 8'hFF;
            tick();
        end
        b1.byte_valid = 1'b0;
        check("bp_memwrite", 32'(b1.memWrite), 1);
        check("bp_data", b1.dataIn, 32'h12AB5E9C);
        tick();
        check("bp_done", 32'(b1.done), 1);
        check("bp_writes", 32'(wr1), 2);

        // Full 16-word load with valid held high
        start16();
        cyc = 1;
        while (!b16.done && cyc < 200) begin
            b16.byte_valid = (byteIdx < 64);
            b16.byte_data  = 8'(byteIdx);
            hs = b16.byte_ready && (byteIdx < 64);
            tick();
            cyc++;
            if (hs) byteIdx++;
        end
        b16.byte_valid = 1'b0;
        check("fl_done_cycle", 32'(cyc), 81);
        check("fl_wcount", 32'(b16.word_count), 16);
        check("fl_writes", 32'(wr16), 16);
        for (int i = 0; i < 16; i++) begin
            check("fl_pc", wrPc[i], 32'(2 * i));
            check("fl_data", wrData[i],
                  {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
        end
        check("fl_pc_final", b16.pc, 32'd30);
        tick();
        check("fl_hold_off", 32'(b16.cpu_hold), 0);
        check("fl_done_off", 32'(b16.done), 0);

        // Abort after two bytes of word 3; the byte offered with abort is dropped
        doneBefore = done16;
        start16();
        feed(14);
        b16.abort      = 1'b1;
        b16.byte_valid = 1'b1;
        b16.byte_data  = 8'hEE;
        tick();
        b16.abort      = 1'b0;
        b16.byte_valid = 1'b0;
        check("ac_ready", 32'(b16.byte_ready), 0);
        check("ac_hold", 32'(b16.cpu_hold), 0);
        check("ac_wcount", 32'(b16.word_count), 3);
        repeat (6) tick();
        check("ac_writes", 32'(wr16), 3);
        check("ac_no_done", 32'(done16), 32'(doneBefore));

        // Abort during the write of word 5: that write still lands
        start16();
        feed(24);
        check("aw_memwrite", 32'(b16.memWrite), 1);
        check("aw_pc", b16.pc, 32'd10);
        b16.abort = 1'b1;
        tick();
        b16.abort = 1'b0;
        check("aw_hold", 32'(b16.cpu_hold), 0);
        check("aw_memwrite_off", 32'(b16.memWrite), 0);
        check("aw_done", 32'(b16.done), 0);
        check("aw_wcount", 32'(b16.word_count), 6);
        check("aw_writes", 32'(wr16), 6);

        // Asynchronous reset while collecting word 7
        start16();
        feed(29);
        #2 reset = 1'b1;
        #1;
        check("mr_ready", 32'(b16.byte_ready), 0);
        check("mr_hold", 32'(b16.cpu_hold), 0);
        check("mr_pc", b16.pc, 0);
        check("mr_datain", b16.dataIn, 0);
        check("mr_wcount", 32'(b16.word_count), 0);
        tick();
        reset = 1'b0;
        tick();
        start16();
        feed(4);
        check("mr_reload_wr", 32'(b16.memWrite), 1);
        check("mr_reload_pc", b16.pc, 0);
        check("mr_reload_data", b16.dataIn, 32'h03020100);
        tick();
        b16.abort = 1'b1;
        tick();
        b16.abort = 1'b0;
        check("mr_reload_wcount", 32'(b16.word_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end
endmodule
